// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream in_* and downstream out_*.
// slave = stage view (accepts in_*, drives out_*); master = the surrounding pipeline.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_ctrl,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_ctrl,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_ctrl,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_ctrl,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register (main + skid) with flush and perf counters.
// Ports: clk, reset (async high), flush, bus (slave handshake), stall_cnt, bubble_cnt.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_skid_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_main_v;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_v;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_stall;
  logic [CNT_W-1:0]  r_bubble;

  logic              w_acc;
  logic              w_drn;
  logic              w_main_v_n;
  logic [CTRL_W-1:0] w_main_ctrl_n;
  logic [DATA_W-1:0] w_main_data_n;
  logic              w_skid_v_n;
  logic [CTRL_W-1:0] w_skid_ctrl_n;
  logic [DATA_W-1:0] w_skid_data_n;
  logic              w_stall;
  logic              w_bubble;

  assign w_acc = bus.in_valid & r_in_ready;
  assign w_drn = r_main_v & bus.out_ready;

  // Counters look at the pre-edge state, so a flush cycle still counts.
  assign w_stall  = r_main_v & ~bus.out_ready;
  assign w_bubble = ~r_main_v & bus.out_ready;

  always_comb begin
    w_main_v_n    = r_main_v;
    w_main_ctrl_n = r_main_ctrl;
    w_main_data_n = r_main_data;
    w_skid_v_n    = r_skid_v;
    w_skid_ctrl_n = r_skid_ctrl;
    w_skid_data_n = r_skid_data;

    priority case (1'b1)
      flush: begin
        w_main_v_n    = 1'b0;
        w_main_ctrl_n = '0;
        w_skid_v_n    = 1'b0;
        w_skid_ctrl_n = '0;
      end
      // Skid full implies in_ready=0, so no accept can coincide here.
      (w_drn & r_skid_v): begin
        w_main_v_n    = 1'b1;
        w_main_ctrl_n = r_skid_ctrl;
        w_main_data_n = r_skid_data;
        w_skid_v_n    = 1'b0;
        w_skid_ctrl_n = '0;
      end
      (w_acc & (~r_main_v | w_drn)): begin
        w_main_v_n    = 1'b1;
        w_main_ctrl_n = bus.in_ctrl;
        w_main_data_n = bus.in_data;
      end
      (w_acc & r_main_v & ~w_drn): begin
        w_skid_v_n    = 1'b1;
        w_skid_ctrl_n = bus.in_ctrl;
        w_skid_data_n = bus.in_data;
      end
      // Data is left as-is: bubble payload is don't-care, ctrl is a NOP.
      w_drn: begin
        w_main_v_n    = 1'b0;
        w_main_ctrl_n = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_v    <= 1'b0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_v    <= 1'b0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      r_main_v    <= w_main_v_n;
      r_main_ctrl <= w_main_ctrl_n;
      r_main_data <= w_main_data_n;
      r_skid_v    <= w_skid_v_n;
      r_skid_ctrl <= w_skid_ctrl_n;
      r_skid_data <= w_skid_data_n;
      // Registered copy keeps out_ready off the in_ready path.
      r_in_ready  <= ~w_skid_v_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall  <= '0;
      r_bubble <= '0;
    end else begin
      if (w_stall && r_stall != CNT_MAX)
        r_stall <= r_stall + CNT_ONE;
      if (w_bubble && r_bubble != CNT_MAX)
        r_bubble <= r_bubble + CNT_ONE;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_main_v;
  assign bus.out_ctrl  = r_main_ctrl;
  assign bus.out_data  = r_main_data;
  assign stall_cnt     = r_stall;
  assign bubble_cnt    = r_bubble;

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W, 64, payload width (PC, operand data, immediates); not cleared on flush.
  CTRL_W, 16, control-field width (RegWrite, MemWrite, MemRead, Branch, ...); zeroed on flush/bubble.
  CNT_W, 16, width of the performance counters.
REQ-002 Ports SHALL be, one per line:
  clk  input  1  rising-edge clock, sole clock.
  reset  input  1  asynchronous, active-high reset.
  flush  input  1  synchronous kill of all held entries.
  in_valid  input  1  upstream stage presents an entry.
  in_ready  output  1  stage can accept an entry.
  in_ctrl  input  CTRL_W  upstream control fields.
  in_data  input  DATA_W  upstream payload.
  out_valid  output  1  stage presents an entry downstream.
  out_ready  input  1  downstream accepts this cycle.
  out_ctrl  output  CTRL_W  control fields of the presented entry.
  out_data  output  DATA_W  payload of the presented entry.
  stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
  bubble_cnt  output  CNT_W  cycles with out_valid=0 and out_ready=1.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high, port names clk and reset.

Function
REQ-004 Storage SHALL be two entries: main (drives out_*) and skid; each has a valid bit.
REQ-005 in_ready SHALL be a registered signal equal to NOT skid_valid; no combinational path from out_ready to in_ready.
REQ-006 Accept SHALL occur on a clk edge with in_valid=1 and in_ready=1; drain SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-007 Accept into main when main is empty or draining the same edge with skid empty; otherwise accept into skid.
REQ-008 On drain with skid full, skid SHALL move to main the same edge and skid_valid SHALL clear.
REQ-009 Latency input-to-output SHALL be exactly 1 cycle when main is empty; throughput SHALL be 1 entry/cycle with out_ready held high.
REQ-010 Entry order SHALL be preserved; no entry is duplicated or dropped except by flush.
REQ-011 out_valid SHALL equal main_valid, out_ctrl SHALL read all zeros in every cycle out_valid=0 (bubble is a NOP).
REQ-012 flush=1 SHALL clear main_valid, skid_valid and both ctrl registers at the edge; an entry offered the same edge SHALL be discarded; in_ready SHALL be 1 the following cycle.
REQ-013 flush SHALL take priority over accept, drain and skid-to-main move.
REQ-014 out_data SHALL hold its last value while out_valid=0 (don't-care for consumers, not cleared).
REQ-015 stall_cnt and bubble_cnt SHALL increment by 1 per qualifying edge, saturate at 2^CNT_W-1, and not wrap.
REQ-016 Counters SHALL count during flush cycles using pre-flush out_valid; only reset clears them.
REQ-017 out_* SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-018 reset=1 SHALL immediately (no clock) force main_valid=0, skid_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, bubble_cnt=0, in_ready=1.
REQ-019 Reset asserted mid-transfer SHALL discard both entries; first accept after release SHALL appear on out_* 1 cycle later.

Verification
REQ-020 Streaming: out_ready=1, in_valid=1 for 8 cycles with in_data=1..8 -> out_data 1..8 on consecutive cycles, 1-cycle latency, stall_cnt=0.
REQ-021 Back-pressure: stream A,B,C, out_ready=0 after A presented -> B captured in skid, in_ready=0 next cycle, C held upstream; release -> A,B,C in order, stall_cnt equals held cycles.
REQ-022 Flush with full skid: main=A, skid=B, flush=1 with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, C never appears.
REQ-023 Saturation: CNT_W=4, out_valid=0, out_ready=1 for 20 cycles -> bubble_cnt reaches 15 and stays 15.
REQ-024 Async reset: assert reset between edges with both entries full -> out_valid=0, counters=0, in_ready=1 before next clk edge.
REQ-025 Random in_valid/out_ready/flush (10k cycles) vs scoreboard -> no loss, duplication or reorder outside flush; out_ctrl=0 whenever out_valid=0.
